// File: rtl/core_id_issue.sv
`default_nettype none
// ============================================================================
// Module   : core_id_issue
// Purpose  : Operand-fetch / issue stage. Holds one decoded instruction,
//            reads the register file, forwards in-flight EX / WB results,
//            stalls on a load-use dependency and hands the instruction plus
//            resolved operands to EX over a valid/ready handshake.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            valid_in/ready_in   - decoder handshake, i_* instruction fields
//            rf_rs*_idx/rf_rs*_dat - combinational register-file read ports
//            ex_fwd_*, ex_load_pend - EX result forward / pending load
//            wb_fwd_*            - register-file write in progress
//            flush_req           - commit flush from EX
//            valid_out/ready_out - EX handshake, o_* issued instruction
//            stall_cnt           - saturating count of load-use stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module core_id_issue #(
    parameter int XLEN        = 32,
    parameter int PC_WIDTH    = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int BJ_W        = 8,
    parameter int ALU_W       = 16,
    parameter int LSU_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic [PC_WIDTH-1:0]    i_pc,
    input  logic                   i_branch_predict,
    input  logic [XLEN-1:0]        i_imm,
    input  logic                   i_rs1_ren,
    input  logic                   i_rs2_ren,
    input  logic                   i_rd_wen,
    input  logic [RFIDX_WIDTH-1:0] i_rs1_idx,
    input  logic [RFIDX_WIDTH-1:0] i_rs2_idx,
    input  logic [RFIDX_WIDTH-1:0] i_rd_idx,
    input  logic [BJ_W-1:0]        i_bj_dec_inst_bus,
    input  logic [ALU_W-1:0]       i_alu_inst_bus,
    input  logic [LSU_W-1:0]       i_lsu_inst_bus,
    output logic [RFIDX_WIDTH-1:0] rf_rs1_idx,
    output logic [RFIDX_WIDTH-1:0] rf_rs2_idx,
    input  logic [XLEN-1:0]        rf_rs1_dat,
    input  logic [XLEN-1:0]        rf_rs2_dat,
    input  logic                   ex_fwd_en,
    input  logic [RFIDX_WIDTH-1:0] ex_fwd_idx,
    input  logic [XLEN-1:0]        ex_fwd_dat,
    input  logic                   ex_load_pend,
    input  logic                   wb_fwd_en,
    input  logic [RFIDX_WIDTH-1:0] wb_fwd_idx,
    input  logic [XLEN-1:0]        wb_fwd_dat,
    input  logic                   flush_req,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic [PC_WIDTH-1:0]    o_pc,
    output logic                   o_branch_predict,
    output logic [XLEN-1:0]        o_imm,
    output logic [XLEN-1:0]        o_rs1_dat,
    output logic [XLEN-1:0]        o_rs2_dat,
    output logic                   o_rs1_ren,
    output logic                   o_rs2_ren,
    output logic                   o_rd_wen,
    output logic [RFIDX_WIDTH-1:0] o_rs1_idx,
    output logic [RFIDX_WIDTH-1:0] o_rs2_idx,
    output logic [RFIDX_WIDTH-1:0] o_rd_idx,
    output logic [BJ_W-1:0]        o_bj_dec_inst_bus,
    output logic [ALU_W-1:0]       o_alu_inst_bus,
    output logic [LSU_W-1:0]       o_lsu_inst_bus,
    output logic [31:0]            stall_cnt
);

    localparam logic [RFIDX_WIDTH-1:0] c_X0      = '0;
    localparam logic [31:0]            c_CNT_MAX = 32'hFFFF_FFFF;

    // Stage register
    logic                   r_vld;
    logic [PC_WIDTH-1:0]    r_pc;
    logic                   r_branch_predict;
    logic [XLEN-1:0]        r_imm;
    logic                   r_rs1_ren;
    logic                   r_rs2_ren;
    logic                   r_rd_wen;
    logic [RFIDX_WIDTH-1:0] r_rs1_idx;
    logic [RFIDX_WIDTH-1:0] r_rs2_idx;
    logic [RFIDX_WIDTH-1:0] r_rd_idx;
    logic [BJ_W-1:0]        r_bj_bus;
    logic [ALU_W-1:0]       r_alu_bus;
    logic [LSU_W-1:0]       r_lsu_bus;
    logic [31:0]            r_stall_cnt;

    logic                   w_haz;
    logic                   w_fire;
    logic                   w_accept;
    logic                   w_valid_out;
    logic                   w_ready_in;
    logic [XLEN-1:0]        w_rs1_dat;
    logic [XLEN-1:0]        w_rs2_dat;

    // Operand resolve: x0 is hard zero, then the youngest producer (EX)
    // wins over the older one (WB), then the architectural register file.
    function automatic logic [XLEN-1:0] f_resolve(
        input logic [RFIDX_WIDTH-1:0] idx,
        input logic [XLEN-1:0]        rf_dat,
        input logic                   ex_en,
        input logic [RFIDX_WIDTH-1:0] ex_idx,
        input logic [XLEN-1:0]        ex_dat,
        input logic                   wb_en,
        input logic [RFIDX_WIDTH-1:0] wb_idx,
        input logic [XLEN-1:0]        wb_dat
    );
        logic [XLEN-1:0] v;
        if (idx == c_X0)                      v = '0;
        else if (ex_en && (ex_idx == idx))    v = ex_dat;
        else if (wb_en && (wb_idx == idx))    v = wb_dat;
        else                                  v = rf_dat;
        return v;
    endfunction

    always_comb begin
        w_rs1_dat = f_resolve(r_rs1_idx, rf_rs1_dat, ex_fwd_en, ex_fwd_idx, ex_fwd_dat,
                              wb_fwd_en, wb_fwd_idx, wb_fwd_dat);
        w_rs2_dat = f_resolve(r_rs2_idx, rf_rs2_dat, ex_fwd_en, ex_fwd_idx, ex_fwd_dat,
                              wb_fwd_en, wb_fwd_idx, wb_fwd_dat);
    end

    // Load-use: the pending load's destination is carried on ex_fwd_idx.
    // A load to x0 never blocks anything.
    assign w_haz = r_vld && ex_load_pend && (ex_fwd_idx != c_X0) &&
                   ((r_rs1_ren && (r_rs1_idx == ex_fwd_idx)) ||
                    (r_rs2_ren && (r_rs2_idx == ex_fwd_idx)));

    // Flush masks valid_out so a simultaneous ready_out cannot issue.
    assign w_valid_out = r_vld && !w_haz && !flush_req;
    assign w_fire      = w_valid_out && ready_out;
    // Accepting while issuing keeps the stage at one instruction per cycle.
    assign w_ready_in  = !flush_req && (!r_vld || w_fire);
    assign w_accept    = valid_in && w_ready_in;

    always_ff @(posedge clk) begin
        if (rst || flush_req)  r_vld <= 1'b0;
        else if (w_accept)     r_vld <= 1'b1;
        else if (w_fire)       r_vld <= 1'b0;
    end

    // Control bits carry a reset so a fresh stage never presents stale enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_predict <= 1'b0;
            r_rs1_ren        <= 1'b0;
            r_rs2_ren        <= 1'b0;
            r_rd_wen         <= 1'b0;
            r_bj_bus         <= '0;
            r_alu_bus        <= '0;
            r_lsu_bus        <= '0;
        end else if (w_accept) begin
            r_branch_predict <= i_branch_predict;
            r_rs1_ren        <= i_rs1_ren;
            r_rs2_ren        <= i_rs2_ren;
            r_rd_wen         <= i_rd_wen;
            r_bj_bus         <= i_bj_dec_inst_bus;
            r_alu_bus        <= i_alu_inst_bus;
            r_lsu_bus        <= i_lsu_inst_bus;
        end
    end

    // Data fields are qualified by r_vld downstream and need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc      <= i_pc;
            r_imm     <= i_imm;
            r_rs1_idx <= i_rs1_idx;
            r_rs2_idx <= i_rs2_idx;
            r_rd_idx  <= i_rd_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                   r_stall_cnt <= '0;
        else if (w_haz && (r_stall_cnt != c_CNT_MAX)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign ready_in          = w_ready_in;
    assign valid_out         = w_valid_out;
    assign rf_rs1_idx        = r_rs1_idx;
    assign rf_rs2_idx        = r_rs2_idx;
    assign o_pc              = r_pc;
    assign o_branch_predict  = r_branch_predict;
    assign o_imm             = r_imm;
    assign o_rs1_dat         = w_rs1_dat;
    assign o_rs2_dat         = w_rs2_dat;
    assign o_rs1_ren         = r_rs1_ren;
    assign o_rs2_ren         = r_rs2_ren;
    assign o_rd_wen          = r_rd_wen;
    assign o_rs1_idx         = r_rs1_idx;
    assign o_rs2_idx         = r_rs2_idx;
    assign o_rd_idx          = r_rd_idx;
    assign o_bj_dec_inst_bus = r_bj_bus;
    assign o_alu_inst_bus    = r_alu_bus;
    assign o_lsu_inst_bus    = r_lsu_bus;
    assign stall_cnt         = r_stall_cnt;

endmodule
`default_nettype wire
